// File: rtl/booth_mult_pkg.sv
// rtl/booth_mult_pkg.sv - shared types and constants for the Booth multiplier controller
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Booth pair is {Q[0], Q_1}; 01 adds M, 10 subtracts M, 00/11 skip.
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    function automatic logic pair_is_op(input logic [1:0] pair);
        return (pair == PAIR_ADD) || (pair == PAIR_SUB);
    endfunction

endpackage

// File: rtl/booth_addsub_unit.sv
// rtl/booth_addsub_unit.sv - W-bit ripple add/sub, mode 0 adds, mode 1 subtracts
module booth_addsub_unit #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_x;
    logic [W-1:0] carry;

    assign carry[0] = mode;

    // The top stage only needs its sum bit, so no carry-out is produced.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        xor_gate u_binv (
            .a (b[gi]),
            .b (mode),
            .y (b_x[gi])
        );
        if (gi < W - 1) begin : g_fa
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b_x[gi]),
                .cin  (carry[gi]),
                .s    (sum[gi]),
                .cout (carry[gi+1])
            );
        end else begin : g_msb
            logic half;
            xor_gate u_s0 (
                .a (a[gi]),
                .b (b_x[gi]),
                .y (half)
            );
            xor_gate u_s1 (
                .a (half),
                .b (carry[gi]),
                .y (sum[gi])
            );
        end
    end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/xor_gate.sv
// rtl/xor_gate.sv - two-input xor cell
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - radix-2 Booth sequential signed multiplier controller
module booth_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [CNT_W-1:0]     op_count_o
);

    import booth_mult_pkg::*;

    state_t             state;
    state_t             state_nx;

    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   tally;

    logic [1:0]         pair;
    logic               mode;
    logic               do_op;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_op;
    logic [WIDTH:0]     acc_sh;
    logic [WIDTH-1:0]   q_sh;
    logic [CNT_W-1:0]   tally_nx;
    logic               accept;
    logic               last_iter;

    booth_addsub_unit #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a    (acc),
        .b    (m_reg),
        .mode (mode),
        .sum  (sum)
    );

    always_comb begin
        pair     = {q[0], q_1};
        mode     = (pair == PAIR_SUB) ? SUB : ADD;
        do_op    = pair_is_op(pair);
        acc_op   = do_op ? sum : acc;
        // Arithmetic right shift of {acc_op, q, q_1}: acc MSB replicates.
        acc_sh   = {acc_op[WIDTH], acc_op[WIDTH:1]};
        q_sh     = {acc_op[0], q[WIDTH-1:1]};
        tally_nx = do_op ? tally + 1'b1 : tally;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx  = DONE;
                    last_iter = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            m_reg      <= '0;
            q          <= '0;
            q_1        <= 1'b0;
            cnt        <= '0;
            tally      <= '0;
            product_o  <= '0;
            op_count_o <= '0;
        end else if (accept) begin
            m_reg <= {mcand_i[WIDTH-1], mcand_i};
            q     <= mplier_i;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            tally <= '0;
        end else if (state == RUN) begin
            acc   <= acc_sh;
            q     <= q_sh;
            q_1   <= q[0];
            cnt   <= cnt - 1'b1;
            tally <= tally_nx;
            if (last_iter) begin
                product_o  <= {acc_sh[WIDTH-1:0], q_sh};
                op_count_o <= tally_nx;
            end
        end
    end

    assign busy_o = (state == RUN);
    assign done_o = (state == DONE);

endmodule
